// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memory op codes, FSM states and
// small decode helpers for byte enables and store data.
package mem_stage_pkg;

  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] MEM_LB  = 8'h01;
  localparam logic [7:0] MEM_LW  = 8'h02;
  localparam logic [7:0] MEM_SB  = 8'h03;
  localparam logic [7:0] MEM_SW  = 8'h04;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW) || (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_word_op(input logic [7:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

  function automatic logic [3:0] byte_en(input logic [7:0] op, input logic [1:0] lo);
    return is_word_op(op) ? 4'hF : (4'b0001 << lo);
  endfunction

  // Byte stores replicate the byte on every lane so the slave can pick by be.
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    if (op == MEM_SW) return d;
    if (op == MEM_SB) return {4{d[7:0]}};
    return 32'h0;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/ack data bus between the memory stage and memory.
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_load_align: little-endian load alignment; LB is sign-extended, LW passes
// through. Kept separate so further load widths slot in here.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    data = 32'h0;
    if (mem_op == MEM_LB) data = {{24{byte_sel[7]}}, byte_sel};
    else if (mem_op == MEM_LW) data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: LB/LW/SB/SW over a req/ack bus with upstream
// stall and bus timeout. Optional MEM_UNALIGNED_TRAP_EN traps unaligned LW/SW.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] wdata,
  input  logic [4:0]  waddr,
  input  logic        we,
  output logic        stall_req,
  mem_stage_if.master bus,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o
`ifdef MEM_UNALIGNED_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_o_q, wdata_o_d;
  logic [4:0]  waddr_o_q, waddr_o_d;
  logic        we_o_q, we_o_d;
  logic        misalign_q, misalign_d;
  logic        trap_hit;
  logic [31:0] load_data;

`ifdef MEM_UNALIGNED_TRAP_EN
  assign trap_hit   = is_word_op(mem_op) && (mem_addr[1:0] != 2'b00);
  assign misalign_o = misalign_q;
`else
  assign trap_hit   = 1'b0;
`endif

  mem_load_align u_align (
    .mem_op (op_q),
    .addr   (addr_lo_q),
    .rdata  (rdata_q),
    .data   (load_data)
  );

  // Stall depends only on state and the incoming op, never on bus_ack.
  assign stall_req = !rst && (((state_q == MEM_ST_IDLE) && is_mem_op(mem_op)) ||
                              (state_q == MEM_ST_BUSY));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    rdata_d     = rdata_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    wdata_o_d   = wdata_o_q;
    waddr_o_d   = waddr_o_q;
    we_o_d      = we_o_q;
    misalign_d  = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (is_mem_op(mem_op)) begin
          op_d      = mem_op;
          addr_lo_d = mem_addr[1:0];
          cnt_d     = '0;
          we_o_d    = 1'b0;
          if (trap_hit) begin
            state_d    = MEM_ST_DONE;
            rdata_d    = 32'h0;
            misalign_d = 1'b1;
          end else begin
            state_d     = MEM_ST_BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store(mem_op);
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_be_d    = byte_en(mem_op, mem_addr[1:0]);
            bus_wdata_d = store_data(mem_op, mem_data);
          end
        end else begin
          wdata_o_d = wdata;
          waddr_o_d = waddr;
          we_o_d    = we;
        end
      end
      MEM_ST_BUSY: begin
        if (bus.bus_ack) begin
          rdata_d   = bus.bus_rdata;
          bus_req_d = 1'b0;
          state_d   = MEM_ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = 32'h0;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          state_d   = MEM_ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_ST_DONE: begin
        state_d   = MEM_ST_IDLE;
        waddr_o_d = waddr;
        // misalign_q is high only in the DONE cycle of a trapped access.
        we_o_d    = we && !misalign_q;
        wdata_o_d = is_load(op_q) ? load_data : wdata;
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      bus_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
      op_q        <= MEM_NOP;
      addr_lo_q   <= 2'b00;
      wdata_o_q   <= 32'h0;
      waddr_o_q   <= 5'd0;
      we_o_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      wdata_o_q   <= wdata_o_d;
      waddr_o_q   <= waddr_o_d;
      we_o_q      <= we_o_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_err   = bus_err_q;
  assign wdata_o       = wdata_o_q;
  assign waddr_o       = waddr_o_q;
  assign we_o          = we_o_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scripted bus slave (BUS_TIMEOUT = 8).
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        we;
  logic        stall_req;
  logic [31:0] wdata_o;
  logic [4:0]  waddr_o;
  logic        we_o;
`ifdef MEM_UNALIGNED_TRAP_EN
  logic        misalign_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  mem_stage_if bus ();

  mem_stage #(.BUS_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wdata     (wdata),
    .waddr     (waddr),
    .we        (we),
    .stall_req (stall_req),
    .bus       (bus.master),
    .wdata_o   (wdata_o),
    .waddr_o   (waddr_o),
    .we_o      (we_o)
`ifdef MEM_UNALIGNED_TRAP_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one memory op to commit; wait_n < 0 means the slave never acks.
  int          r_stalls, r_req, r_err, r_stable, r_weo_stall, r_mis;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  task automatic access(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] mdata, input logic [31:0] wd,
                        input logic [4:0] wa, input logic w_en,
                        input int wait_n, input logic [31:0] rd);
    mem_op = op; mem_addr = addr; mem_data = mdata;
    wdata = wd; waddr = wa; we = w_en;
    r_stalls = 0; r_req = 0; r_err = 0; r_stable = 1; r_weo_stall = 0; r_mis = 0;
    r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!stall_req) break;
      r_stalls++;
      if (bus.bus_err) r_err++;
      if (bus.bus_req) begin
        r_req++;
        if (we_o) r_weo_stall++;
        if (r_req == 1) begin
          r_addr = bus.bus_addr; r_wdata = bus.bus_wdata;
          r_be = bus.bus_be; r_we = bus.bus_we;
        end else if (bus.bus_addr !== r_addr || bus.bus_wdata !== r_wdata ||
                     bus.bus_be !== r_be || bus.bus_we !== r_we) begin
          r_stable = 0;
        end
        if (wait_n >= 0 && r_req == wait_n + 1) begin
          bus.bus_ack = 1'b1;
          bus.bus_rdata = rd;
        end
      end
      tick();
      bus.bus_ack = 1'b0;
      bus.bus_rdata = 32'h0;
    end
    if (bus.bus_err) r_err++;
`ifdef MEM_UNALIGNED_TRAP_EN
    if (misalign_o) r_mis++;
`endif
    tick();
    mem_op = MEM_NOP;
  endtask

  initial begin
    rst = 1'b1;
    mem_op = MEM_NOP; mem_addr = '0; mem_data = '0;
    wdata = '0; waddr = '0; we = 1'b0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    tick(); tick();
    chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_wdata_o", wdata_o, 32'd0);
    chk("rst_we_o", {31'd0, we_o}, 32'd0);
    chk("rst_be", {28'd0, bus.bus_be}, 32'd0);
    rst = 1'b0;
    tick();

    // Pass-through
    wdata = 32'h1234_5678; waddr = 5'd5; we = 1'b1;
    #1;
    chk("nop_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("nop_wdata_o", wdata_o, 32'h1234_5678);
    chk("nop_waddr_o", {27'd0, waddr_o}, 32'd5);
    chk("nop_we_o", {31'd0, we_o}, 32'd1);

    // LB zero-wait, top byte, negative
    access(MEM_LB, 32'h0100_0003, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 0, 32'h8000_0000);
    chk("lb_stalls", r_stalls, 32'd2);
    chk("lb_req_cyc", r_req, 32'd1);
    chk("lb_addr", r_addr, 32'h0100_0000);
    chk("lb_be", {28'd0, r_be}, 32'h8);
    chk("lb_we", {31'd0, r_we}, 32'd0);
    chk("lb_weo_stall", r_weo_stall, 32'd0);
    chk("lb_wdata_o", wdata_o, 32'hFFFF_FF80);
    chk("lb_waddr_o", {27'd0, waddr_o}, 32'd7);
    chk("lb_we_o", {31'd0, we_o}, 32'd1);

    // LB positive byte in lane 1
    access(MEM_LB, 32'h0000_0011, 32'h0, 32'h0, 5'd3, 1'b1, 0, 32'h0000_7F00);
    chk("lb1_be", {28'd0, r_be}, 32'h2);
    chk("lb1_wdata_o", wdata_o, 32'h0000_007F);

    // SB with 3 wait cycles
    access(MEM_SB, 32'h0200_0001, 32'h0000_00AB, 32'h5555_AAAA, 5'd9, 1'b0, 3, 32'h0);
    chk("sb_stalls", r_stalls, 32'd5);
    chk("sb_req_cyc", r_req, 32'd4);
    chk("sb_stable", r_stable, 32'd1);
    chk("sb_we", {31'd0, r_we}, 32'd1);
    chk("sb_be", {28'd0, r_be}, 32'h2);
    chk("sb_wdata", r_wdata, 32'hABAB_ABAB);
    chk("sb_addr", r_addr, 32'h0200_0000);
    chk("sb_we_o", {31'd0, we_o}, 32'd0);
    chk("sb_wdata_o", wdata_o, 32'h5555_AAAA);

    // SW zero-wait
    access(MEM_SW, 32'h0000_0040, 32'h1122_3344, 32'h0, 5'd0, 1'b0, 0, 32'h0);
    chk("sw_be", {28'd0, r_be}, 32'hF);
    chk("sw_wdata", r_wdata, 32'h1122_3344);

    // LW with 1 wait
    access(MEM_LW, 32'h0000_0080, 32'h0, 32'h0, 5'd12, 1'b1, 1, 32'hCAFE_BABE);
    chk("lw_stalls", r_stalls, 32'd3);
    chk("lw_wdata_o", wdata_o, 32'hCAFE_BABE);
    chk("lw_wdata_bus", r_wdata, 32'h0);

    // Timeout: no ack
    access(MEM_LW, 32'h0300_0004, 32'h0, 32'h0, 5'd4, 1'b1, -1, 32'h0);
    chk("to_req_cyc", r_req, 32'd8);
    chk("to_stalls", r_stalls, 32'd9);
    chk("to_err_pulses", r_err, 32'd1);
    chk("to_wdata_o", wdata_o, 32'h0);
    chk("to_err_after", {31'd0, bus.bus_err}, 32'd0);

    // Stray ack in IDLE is ignored
    wdata = 32'h0BAD_F00D; waddr = 5'd2; we = 1'b1;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("stray_req", {31'd0, bus.bus_req}, 32'd0);
    chk("stray_stall", {31'd0, stall_req}, 32'd0);
    chk("stray_wdata_o", wdata_o, 32'h0BAD_F00D);

    // Async reset mid-BUSY
    mem_op = MEM_LW; mem_addr = 32'h0400_0008; we = 1'b1; waddr = 5'd6;
    tick();
    chk("ar_busy_req", {31'd0, bus.bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", {31'd0, bus.bus_req}, 32'd0);
    chk("ar_stall", {31'd0, stall_req}, 32'd0);
    chk("ar_wdata_o", wdata_o, 32'd0);
    tick();
    rst = 1'b0;
    access(MEM_LW, 32'h0400_0008, 32'h0, 32'h0, 5'd6, 1'b1, 1, 32'h1357_2468);
    chk("ar_lw_stalls", r_stalls, 32'd3);
    chk("ar_lw_wdata_o", wdata_o, 32'h1357_2468);
    chk("ar_lw_waddr_o", {27'd0, waddr_o}, 32'd6);

`ifdef MEM_UNALIGNED_TRAP_EN
    access(MEM_SW, 32'h0000_0002, 32'h7777_7777, 32'h0, 5'd1, 1'b1, 0, 32'h0);
    chk("trap_req_cyc", r_req, 32'd0);
    chk("trap_stalls", r_stalls, 32'd1);
    chk("trap_mis", r_mis, 32'd1);
    chk("trap_we_o", {31'd0, we_o}, 32'd0);
`else
    // Unaligned LW ignores the low address bits
    access(MEM_LW, 32'h0000_0102, 32'h0, 32'h0, 5'd8, 1'b1, 0, 32'h89AB_CDEF);
    chk("ulw_addr", r_addr, 32'h0000_0100);
    chk("ulw_be", {28'd0, r_be}, 32'hF);
    chk("ulw_wdata_o", wdata_o, 32'h89AB_CDEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
